// File: rtl/speed_profile_planner.sv
// Multi-axis stepper timing planner: N, nn, t0, tna and delta per axis through one shared divider.
// Optional build macro PLANNER_SPEED_CLAMP_EN limits latched speed and jerk to MAX_SPEED.
module speed_profile_planner #(
    parameter int unsigned AXES      = 4,
    parameter int unsigned W         = 32,
    parameter int unsigned WT        = 64,
    parameter int unsigned MAIN_FREQ = 50000000,
    parameter int unsigned MAX_SPEED = 200000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [AXES-1:0]       const_speed,
    input  logic [AXES*W-1:0]     num,
    input  logic [AXES*W-1:0]     speed,
    input  logic [AXES*W-1:0]     acceleration,
    input  logic [AXES*W-1:0]     jerk,
    output logic                  busy,
    output logic                  done,
    output logic [AXES-1:0]       dir,
    output logic [AXES-1:0]       err,
    output logic [AXES*5*W-1:0]   params
);

    localparam int unsigned   KW       = (AXES > 1) ? $clog2(AXES) : 1;
    localparam int unsigned   CW       = $clog2(WT + 1);
    localparam logic [W-1:0]  FREQ_W   = W'(MAIN_FREQ);
    localparam logic [WT-1:0] FREQ_WT  = WT'(MAIN_FREQ);
    localparam logic [WT-1:0] FREQ2_WT = FREQ_WT << 1;
    localparam logic [KW-1:0] LAST_K   = KW'(AXES - 1);
    localparam logic [W-1:0]  MAX_W    = W'(MAX_SPEED);

    typedef enum logic [3:0] {
        StIdle, StLatch, StAbs, StT0, StTna, StProd,
        StDelta, StFix, StNn, StTn, StNext, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                div_pend_q, div_pend_d;
    logic [W-1:0]        n_q, n_d, t0_q, t0_d, tna_q, tna_d, nn_q, nn_d;
    logic [WT-1:0]       delta_q, delta_d, prod_q, prod_d;
    logic [AXES-1:0]     dir_q, dir_d, err_q, err_d, cs_q;
    logic [AXES*W-1:0]   num_q, acc_q, speed_q, speed_d, jerk_q, jerk_d;
    logic [AXES*5*W-1:0] params_q, params_d;
    logic                accept;

    logic [W-1:0]        cur_num, cur_speed, cur_acc, cur_jerk, diff;
    logic                cur_const;

    // Shared restoring divider
    logic                div_start, div_busy_q, div_done_q, div_fit;
    logic [WT-1:0]       div_a, div_b, div_rem_q, div_quo_q, div_den_q;
    logic [WT:0]         div_sh;
    logic [CW-1:0]       div_cnt_q;

    assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
    assign cur_num   = num_q[int'(k_q) * W +: W];
    assign cur_speed = speed_q[int'(k_q) * W +: W];
    assign cur_acc   = acc_q[int'(k_q) * W +: W];
    assign cur_jerk  = jerk_q[int'(k_q) * W +: W];
    assign cur_const = cs_q[k_q];
    assign diff      = t0_q - tna_q;

    assign busy   = (state_q != StIdle) && (state_q != StDone);
    assign done   = (state_q == StDone);
    assign dir    = dir_q;
    assign err    = err_q;
    assign params = params_q;

`ifdef PLANNER_SPEED_CLAMP_EN
    always_comb begin
        speed_d = speed_q;
        jerk_d  = jerk_q;
        if (accept) begin
            speed_d = speed;
            jerk_d  = jerk;
        end else if (state_q == StLatch) begin
            for (int i = 0; i < int'(AXES); i++) begin
                if (speed_q[i*W +: W] > MAX_W) speed_d[i*W +: W] = MAX_W;
                if (jerk_q[i*W +: W] > MAX_W)  jerk_d[i*W +: W]  = MAX_W;
            end
        end
    end
`else
    always_comb begin
        speed_d = accept ? speed : speed_q;
        jerk_d  = accept ? jerk : jerk_q;
    end

    logic unused_max_speed;
    assign unused_max_speed = ^MAX_W;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_q   <= '0;
            acc_q   <= '0;
            cs_q    <= '0;
            speed_q <= '0;
            jerk_q  <= '0;
        end else begin
            speed_q <= speed_d;
            jerk_q  <= jerk_d;
            if (accept) begin
                num_q <= num;
                acc_q <= acceleration;
                cs_q  <= const_speed;
            end
        end
    end

    assign div_sh  = {div_rem_q, div_quo_q[WT-1]};
    assign div_fit = div_sh >= {1'b0, div_den_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_busy_q <= 1'b0;
            div_done_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_quo_q  <= '0;
            div_den_q  <= '0;
        end else begin
            div_done_q <= 1'b0;
            if (div_start) begin
                div_busy_q <= 1'b1;
                div_cnt_q  <= CW'(WT);
                div_rem_q  <= '0;
                div_quo_q  <= div_a;
                div_den_q  <= div_b;
            end else if (div_busy_q) begin
                div_rem_q <= div_fit ? WT'(div_sh - {1'b0, div_den_q}) : div_sh[WT-1:0];
                div_quo_q <= {div_quo_q[WT-2:0], div_fit};
                div_cnt_q <= div_cnt_q - 1'b1;
                if (div_cnt_q == CW'(1)) begin
                    div_busy_q <= 1'b0;
                    div_done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        div_pend_d = div_pend_q;
        n_d        = n_q;
        t0_d       = t0_q;
        tna_d      = tna_q;
        nn_d       = nn_q;
        delta_d    = delta_q;
        prod_d     = prod_q;
        dir_d      = dir_q;
        err_d      = err_q;
        params_d   = params_q;
        div_start  = 1'b0;
        div_a      = '0;
        div_b      = '0;
        if (accept) err_d = '0;

        unique case (state_q)
            StIdle: if (accept) state_d = StLatch;
            StLatch: begin
                k_d     = '0;
                state_d = StAbs;
            end
            StAbs: begin
                n_d          = cur_num[W-1] ? ~cur_num + 1'b1 : cur_num;
                dir_d[k_q]   = cur_num[W-1];
                t0_d         = '0;
                tna_d        = '0;
                nn_d         = '0;
                delta_d      = '0;
                div_pend_d   = 1'b0;
                state_d      = (cur_num == '0) ? StNext : StT0;
            end
            StT0: begin
                if (cur_jerk == '0) begin
                    t0_d    = FREQ_W;
                    state_d = StTna;
                end else if (!div_pend_q) begin
                    div_start  = 1'b1;
                    div_a      = FREQ_WT;
                    div_b      = WT'(cur_jerk);
                    div_pend_d = 1'b1;
                end else if (div_done_q) begin
                    div_pend_d = 1'b0;
                    t0_d       = div_quo_q[W-1:0];
                    state_d    = StTna;
                end
            end
            StTna: begin
                if (cur_speed == '0) begin
                    err_d[k_q] = 1'b1;
                    t0_d       = '0;
                    state_d    = StNext;
                end else if (!div_pend_q) begin
                    div_start  = 1'b1;
                    div_a      = FREQ_WT;
                    div_b      = WT'(cur_speed);
                    div_pend_d = 1'b1;
                end else if (div_done_q) begin
                    div_pend_d = 1'b0;
                    tna_d      = div_quo_q[W-1:0];
                    // No ramp possible: run the whole move at the target period
                    if (cur_const || (cur_speed <= cur_jerk)) begin
                        t0_d    = div_quo_q[W-1:0];
                        nn_d    = '0;
                        delta_d = '0;
                        state_d = StNext;
                    end else begin
                        state_d = StProd;
                    end
                end
            end
            StProd: begin
                prod_d  = (WT'(t0_q) * WT'(t0_q) - WT'(tna_q) * WT'(tna_q)) * WT'(cur_acc);
                state_d = StDelta;
            end
            StDelta: begin
                if (t0_q == tna_q) begin
                    delta_d = '0;
                    state_d = StFix;
                end else if (!div_pend_q) begin
                    div_start  = 1'b1;
                    div_a      = prod_q;
                    div_b      = FREQ2_WT * WT'(cur_speed - cur_jerk);
                    div_pend_d = 1'b1;
                end else if (div_done_q) begin
                    div_pend_d = 1'b0;
                    delta_d    = div_quo_q;
                    state_d    = StFix;
                end
            end
            StFix: begin
                delta_d = delta_q;
                if ((delta_q == '0) && (t0_q != tna_q)) delta_d = WT'(1);
                if (delta_d > WT'(diff)) delta_d = WT'(diff);
                state_d = StNn;
            end
            StNn: begin
                if (delta_q == '0) begin
                    nn_d    = '0;
                    state_d = StTn;
                end else if (!div_pend_q) begin
                    div_start  = 1'b1;
                    div_a      = WT'(diff);
                    div_b      = delta_q;
                    div_pend_d = 1'b1;
                end else if (div_done_q) begin
                    div_pend_d = 1'b0;
                    nn_d       = div_quo_q[W-1:0];
                    state_d    = StTn;
                end
            end
            StTn: begin
                tna_d   = t0_q - delta_q[W-1:0] * nn_q;
                state_d = StNext;
            end
            StNext: begin
                params_d[(int'(k_q) * 5 + 0) * W +: W] = n_q;
                params_d[(int'(k_q) * 5 + 1) * W +: W] = nn_q;
                params_d[(int'(k_q) * 5 + 2) * W +: W] = t0_q;
                params_d[(int'(k_q) * 5 + 3) * W +: W] = tna_q;
                params_d[(int'(k_q) * 5 + 4) * W +: W] = delta_q[W-1:0];
                if (k_q == LAST_K) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StAbs;
                end
            end
            StDone: state_d = accept ? StLatch : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            k_q        <= '0;
            div_pend_q <= 1'b0;
            n_q        <= '0;
            t0_q       <= '0;
            tna_q      <= '0;
            nn_q       <= '0;
            delta_q    <= '0;
            prod_q     <= '0;
            dir_q      <= '0;
            err_q      <= '0;
            params_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            div_pend_q <= div_pend_d;
            n_q        <= n_d;
            t0_q       <= t0_d;
            tna_q      <= tna_d;
            nn_q       <= nn_d;
            delta_q    <= delta_d;
            prod_q     <= prod_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            params_q   <= params_d;
        end
    end

endmodule

// File: tb/tb_speed_profile_planner.sv
// Self-checking bench for speed_profile_planner: directed cases plus randomized moves vs a model.
module tb_speed_profile_planner;

    localparam int unsigned     AXES  = 4;
    localparam int unsigned     W     = 32;
    localparam int unsigned     WT    = 64;
    localparam int unsigned     MAXS  = 1000;
    localparam longint unsigned F     = 64'd50000000;
    localparam int              BOUND = AXES * (4 * (WT + 2) + 10) + 4;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic [AXES-1:0]       const_speed = '0;
    logic [AXES*W-1:0]     num = '0;
    logic [AXES*W-1:0]     speed = '0;
    logic [AXES*W-1:0]     acceleration = '0;
    logic [AXES*W-1:0]     jerk = '0;
    logic                  busy;
    logic                  done;
    logic [AXES-1:0]       dir;
    logic [AXES-1:0]       err;
    logic [AXES*5*W-1:0]   params;

    logic [AXES*5*W-1:0]   exp_params;
    logic [AXES-1:0]       exp_dir;
    logic [AXES-1:0]       exp_err;
    int                    n_checks = 0;
    int                    n_errors = 0;

    speed_profile_planner #(
        .AXES      (AXES),
        .W         (W),
        .WT        (WT),
        .MAIN_FREQ (50000000),
        .MAX_SPEED (MAXS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .const_speed  (const_speed),
        .num          (num),
        .speed        (speed),
        .acceleration (acceleration),
        .jerk         (jerk),
        .busy         (busy),
        .done         (done),
        .dir          (dir),
        .err          (err),
        .params       (params)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Timing set for one axis straight from the planning arithmetic
    function automatic void model_axis(input logic [W-1:0] num_v, input logic [W-1:0] spd_v,
                                       input logic [W-1:0] acc_v, input logic [W-1:0] jrk_v,
                                       input logic cs, output logic [5*W-1:0] words,
                                       output logic d, output logic e);
        logic [W-1:0]    mag;
        longint unsigned s, j, t0, tna, nn, dl, t;
        s = spd_v;
        j = jrk_v;
`ifdef PLANNER_SPEED_CLAMP_EN
        if (s > MAXS) s = MAXS;
        if (j > MAXS) j = MAXS;
`endif
        mag = num_v[W-1] ? (~num_v + 1'b1) : num_v;
        d = num_v[W-1];
        e = 1'b0;
        words = '0;
        if (num_v == '0) return;
        if (s == 0) begin
            e = 1'b1;
            words[W-1:0] = mag;
            return;
        end
        t0  = (j == 0) ? F : F / j;
        tna = F / s;
        if (cs || s <= j) begin
            t0 = tna;
            nn = 0;
            dl = 0;
        end else begin
            t = (t0 * t0 - tna * tna) * longint'(acc_v);
            dl = (t0 == tna) ? 0 : t / (2 * F * (s - j));
            if (dl == 0 && t0 != tna) dl = 1;
            if (dl > t0 - tna) dl = t0 - tna;
            nn = (dl == 0) ? 0 : (t0 - tna) / dl;
            tna = t0 - dl * nn;
        end
        words = {dl[W-1:0], tna[W-1:0], t0[W-1:0], nn[W-1:0], mag};
    endfunction

    function automatic logic [W-1:0] pw(input int k, input int j);
        return params[(k * 5 + j) * W +: W];
    endfunction

    task automatic set_axis(input int k, input logic [W-1:0] n, input logic [W-1:0] s,
                            input logic [W-1:0] a, input logic [W-1:0] j, input logic c);
        num[k*W +: W]          = n;
        speed[k*W +: W]        = s;
        acceleration[k*W +: W] = a;
        jerk[k*W +: W]         = j;
        const_speed[k]         = c;
    endtask

    task automatic rand_axis(input int k);
        logic [W-1:0] n, s, j;
        int           sel;
        sel = $urandom_range(0, 7);
        n = $urandom();
        if (sel == 0) n = '0;
        else if (sel < 4) n = $urandom_range(1, 200000);
        s = $urandom_range(1, 300000);
        if (sel == 1) s = '0;
        j = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 400000) : $urandom_range(0, s);
        set_axis(k, n, s, $urandom(), j, $urandom_range(0, 3) == 0);
    endtask

    task automatic build_expected();
        logic [5*W-1:0] w;
        logic           d, e;
        for (int k = 0; k < int'(AXES); k++) begin
            model_axis(num[k*W +: W], speed[k*W +: W], acceleration[k*W +: W],
                       jerk[k*W +: W], const_speed[k], w, d, e);
            exp_params[k*5*W +: 5*W] = w;
            exp_dir[k] = d;
            exp_err[k] = e;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < int'(AXES); k++)
            for (int j = 0; j < 5; j++)
                check($sformatf("%s.a%0d.w%0d", tag, k, j), 64'(pw(k, j)),
                      64'(exp_params[(k * 5 + j) * W +: W]));
        check({tag, ".dir"}, 64'(dir), 64'(exp_dir));
        check({tag, ".err"}, 64'(err), 64'(exp_err));
    endtask

    task automatic run(input string tag, input bit poke);
        int cyc;
        bit seen;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= BOUND + 4) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (poke && cyc == 20) begin
                    num   = {$urandom(), $urandom(), $urandom(), $urandom()};
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        check({tag, ".latency"}, 64'(cyc <= BOUND), 64'd1);
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        if (seen) begin
            @(negedge clk);
            check({tag, ".done_pulse"}, 64'(done), 64'd0);
            check({tag, ".busy_after"}, 64'(busy), 64'd0);
        end
        compare_all(tag);
    endtask

    initial begin
        #1;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dir", 64'(dir), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        check("rst.params", 64'(|params), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        set_axis(0, 32'd4000, 32'd1000, 32'd2000, 32'd500, 1'b0);
        set_axis(1, 32'(-1234), 32'd2000, 32'd777, 32'd300, 1'b1);
        set_axis(2, 32'd0, 32'd1500, 32'd10, 32'd10, 1'b0);
        set_axis(3, 32'd10, 32'd0, 32'd5, 32'd5, 1'b0);
        run("accel", 1'b0);
        check("accel.N", 64'(pw(0, 0)), 64'd4000);
        check("accel.nn", 64'(pw(0, 1)), 64'd166);
        check("accel.t0", 64'(pw(0, 2)), 64'd100000);
        check("accel.tna", 64'(pw(0, 3)), 64'd50200);
        check("accel.delta", 64'(pw(0, 4)), 64'd300);
        check("const.N", 64'(pw(1, 0)), 64'd1234);
        check("const.t0", 64'(pw(1, 2)), 64'd25000);
        check("const.tna", 64'(pw(1, 3)), 64'd25000);
        check("const.dir", 64'(dir[1]), 64'd1);
        check("zero.words", 64'(params[2*5*W +: 5*W] != '0), 64'd0);
        check("spd0.err", 64'(err), 64'b1000);
        check("spd0.N", 64'(pw(3, 0)), 64'd10);

        // Outputs must survive idle cycles and input changes without a start
        repeat (20) @(negedge clk);
        for (int k = 0; k < int'(AXES); k++) rand_axis(k);
        @(negedge clk);
        compare_all("hold");

        set_axis(0, 32'd77, 32'd500, 32'd3, 32'd1000, 1'b0);
        set_axis(1, 32'd5, 32'd1000, 32'd1, 32'd0, 1'b0);
        set_axis(2, 32'd9, 32'd5000, 32'd1, 32'd0, 1'b1);
        rand_axis(3);
        run("fallback", 1'b1);
        check("fallback.t0", 64'(pw(0, 2)), 64'd100000);
        check("fallback.tna", 64'(pw(0, 3)), 64'd100000);
        check("fallback.nn", 64'(pw(0, 1)), 64'd0);
        check("fallback.delta", 64'(pw(0, 4)), 64'd0);
        check("jerk0.t0", 64'(pw(1, 2)), 64'd50000000);
`ifdef PLANNER_SPEED_CLAMP_EN
        check("clamp.t0", 64'(pw(2, 2)), 64'd50000);
`else
        check("clamp.t0", 64'(pw(2, 2)), 64'd10000);
`endif

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < int'(AXES); k++) rand_axis(k);
            run($sformatf("rand%0d", r), 1'b0);
        end

        // Abort well into the third axis of an all-ramped job
        for (int k = 0; k < int'(AXES); k++)
            set_axis(k, 32'(1000 + k), 32'd4000, 32'd1234, 32'd1000, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (700) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort.params", 64'(|params), 64'd0);
        check("abort.dir", 64'(dir), 64'd0);
        check("abort.err", 64'(err), 64'd0);
        check("abort.busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort.done", 64'(done), 64'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort.idle_done", 64'(done), 64'd0);
        end
        run("after_abort", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
